// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Fetch-to-decode pipeline register with a one-entry skid buffer.
//
// The stage holds up to two instructions: MAIN, the one currently presented
// to decode, and SKID, which catches a fetch that was accepted in the same
// cycle decode stalled. Because in_ready is decoded purely from the
// registered state, there is no combinational path from stall to in_ready.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   in_valid       fetch presents an instruction
//   in_inst        fetched instruction  [INST_W-1:0]
//   in_pc          its program counter  [PC_W-1:0]
//   in_take        predicted-taken flag
//   in_ready       stage can accept an instruction this cycle
//   stall          decode cannot consume this cycle
//   flush          redirect: kill every held instruction
//   out_valid      an instruction is presented to decode
//   out_inst       presented instruction, NOP_INST when none
//   out_pc         presented PC, holds its last value when none
//   out_take       presented predicted-taken flag, 0 when none
//
// Optional build macro IF_ID_STAGE_PERF_EN adds two saturating counters:
//   stall_cycles   cycles with out_valid & stall
//   flush_count    cycles with flush asserted
// ---------------------------------------------------------------------------
module if_id_stage #(
   parameter int                INST_W   = 32,
   parameter int                PC_W     = 32,
   parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [INST_W-1:0] in_inst,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              in_take,
   output logic              in_ready,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   output logic [INST_W-1:0] out_inst,
   output logic [PC_W-1:0]   out_pc,
   output logic              out_take
`ifdef IF_ID_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_count
`endif
);

   // ------------------------------------------------------------------
   // Occupancy state
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,   // nothing held
      ST_ONE   = 2'd1,   // MAIN only
      ST_TWO   = 2'd2    // MAIN + SKID
   } state_t;

   state_t state_reg;
   state_t state_next;

   // Held entries
   logic [INST_W-1:0] main_inst_reg;
   logic [PC_W-1:0]   main_pc_reg;
   logic              main_take_reg;
   logic [INST_W-1:0] skid_inst_reg;
   logic [PC_W-1:0]   skid_pc_reg;
   logic              skid_take_reg;

   // Handshakes
   logic in_fire;
   logic out_fire;

   // Data-path load controls produced by the next-state logic
   logic load_main_in;     // MAIN <= incoming instruction
   logic load_main_skid;   // MAIN <= SKID (skid drains into presentation slot)
   logic load_skid;        // SKID <= incoming instruction

   // ------------------------------------------------------------------
   // Registered-state decodes
   // ------------------------------------------------------------------
   assign in_ready  = (state_reg != ST_TWO);
   assign out_valid = (state_reg != ST_EMPTY);

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & ~stall;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and load-control logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;

      if (flush) begin
         // Redirect wins over everything; an instruction accepted in the
         // same cycle is dropped along with whatever was held.
         state_next = ST_EMPTY;
      end else begin
         case (state_reg)
            ST_EMPTY: begin
               // stall has no meaning with nothing to present
               if (in_fire) begin
                  load_main_in = 1'b1;
                  state_next   = ST_ONE;
               end
            end

            ST_ONE: begin
               if (out_fire) begin
                  // MAIN is consumed; refill it directly or go empty
                  if (in_fire) begin
                     load_main_in = 1'b1;
                     state_next   = ST_ONE;
                  end else begin
                     state_next   = ST_EMPTY;
                  end
               end else if (in_fire) begin
                  // Decode stalled but fetch delivered: park it in SKID
                  load_skid  = 1'b1;
                  state_next = ST_TWO;
               end
            end

            ST_TWO: begin
               // in_ready is low here, so only the drain can happen
               if (out_fire) begin
                  load_main_skid = 1'b1;
                  state_next     = ST_ONE;
               end
            end

            default: begin
               state_next = ST_EMPTY;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Entry registers
   // ------------------------------------------------------------------
   // MAIN is not cleared on flush so that out_pc keeps its last value
   // while the stage is empty; only reset returns it to zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_inst_reg <= NOP_INST;
         main_pc_reg   <= '0;
         main_take_reg <= 1'b0;
      end else if (load_main_in) begin
         main_inst_reg <= in_inst;
         main_pc_reg   <= in_pc;
         main_take_reg <= in_take;
      end else if (load_main_skid) begin
         main_inst_reg <= skid_inst_reg;
         main_pc_reg   <= skid_pc_reg;
         main_take_reg <= skid_take_reg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_inst_reg <= NOP_INST;
         skid_pc_reg   <= '0;
         skid_take_reg <= 1'b0;
      end else if (load_skid) begin
         skid_inst_reg <= in_inst;
         skid_pc_reg   <= in_pc;
         skid_take_reg <= in_take;
      end
   end

   // ------------------------------------------------------------------
   // Outputs to decode
   // ------------------------------------------------------------------
   // Bubble encoding and a cleared take flag whenever nothing is held;
   // this also covers the cycle after a flush.
   assign out_inst = out_valid ? main_inst_reg : NOP_INST;
   assign out_take = out_valid & main_take_reg;
   assign out_pc   = main_pc_reg;

`ifdef IF_ID_STAGE_PERF_EN
   // ------------------------------------------------------------------
   // Performance counters (saturating)
   // ------------------------------------------------------------------
   logic [31:0] stall_cycles_reg;
   logic [31:0] flush_count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_reg <= '0;
      end else if (out_valid && stall && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
         stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flush_count_reg <= '0;
      end else if (flush && (flush_count_reg != 32'hFFFF_FFFF)) begin
         flush_count_reg <= flush_count_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign flush_count  = flush_count_reg;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
//
// Directed bench for if_id_stage. A queue-based model of the stage (a FIFO
// of at most two instructions) runs alongside the DUT; a compare process
// checks every DUT output against it on each falling edge. The directed
// sequence also carries hand-computed literal expectations that pin the
// model. Build with +define+IF_ID_STAGE_PERF_EN to cover the counters.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        in_take;
   logic        in_ready;
   logic        stall;
   logic        flush;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_take;
`ifdef IF_ID_STAGE_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
`endif

   int total;
   int bad;

   if_id_stage dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_inst   (in_inst),
      .in_pc     (in_pc),
      .in_take   (in_take),
      .in_ready  (in_ready),
      .stall     (stall),
      .flush     (flush),
      .out_valid (out_valid),
      .out_inst  (out_inst),
      .out_pc    (out_pc),
      .out_take  (out_take)
`ifdef IF_ID_STAGE_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Model: in-order queue of accepted instructions, capacity two
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        take;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_last_pc;
   logic [31:0] m_stall_cnt;
   logic [31:0] m_flush_cnt;

   always @(posedge clk or posedge reset) begin
      bit   acc;
      ent_t e;
      if (reset) begin
         mq.delete();
         m_last_pc   = '0;
         m_stall_cnt = '0;
         m_flush_cnt = '0;
      end else begin
         acc = in_valid && (mq.size() < 2);
         if (mq.size() > 0 && stall && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
         if (flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
         if (flush) begin
            mq.delete();
         end else begin
            if (mq.size() > 0 && !stall) void'(mq.pop_front());
            if (acc) begin
               e.inst = in_inst;
               e.pc   = in_pc;
               e.take = in_take;
               mq.push_back(e);
            end
         end
         if (mq.size() > 0) m_last_pc = mq[0].pc;
      end
   end

   // One compare process: every falling edge outside reset
   always @(negedge clk) begin
      if (!reset) begin
         check("in_ready",  in_ready,  (mq.size() < 2));
         check("out_valid", out_valid, (mq.size() > 0));
         check("out_inst",  out_inst,  (mq.size() > 0) ? mq[0].inst : NOP);
         check("out_take",  out_take,  (mq.size() > 0) ? mq[0].take : 1'b0);
         check("out_pc",    out_pc,    m_last_pc);
         check("no_10c",    (out_valid && out_pc == 32'h10C), 1'b0);
`ifdef IF_ID_STAGE_PERF_EN
         check("stall_cycles", stall_cycles, m_stall_cnt);
         check("flush_count",  flush_count,  m_flush_cnt);
`endif
      end
   end

   // Drive inputs for the next rising edge, then settle 1 time unit past it
   task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic tk, input logic st, input logic fl);
      in_valid = v;
      in_inst  = inst;
      in_pc    = pc;
      in_take  = tk;
      stall    = st;
      flush    = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t got=running want=finished", $time);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Directed sequence with literal expectations
   // ------------------------------------------------------------------
   initial begin
      total    = 0;
      bad      = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_inst  = '0;
      in_pc    = '0;
      in_take  = 1'b0;
      stall    = 1'b0;
      flush    = 1'b0;

      // Reset values before any clock edge
      #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_inst",  out_inst,  NOP);
      check("rst_pc",    out_pc,    32'h0);
      check("rst_take",  out_take,  1'b0);
      check("rst_ready", in_ready,  1'b1);
      #11 reset = 1'b0;

      // First fetch, latency one
      cyc(1, 32'h00A00093, 32'h100, 0, 0, 0);
      check("first_valid", out_valid, 1'b1);
      check("first_inst",  out_inst,  32'h00A00093);
      check("first_pc",    out_pc,    32'h100);

      // 0x100 consumed as 0x104 arrives; then stall three cycles with 0x108
      cyc(1, 32'h00400113, 32'h104, 0, 0, 0);
      check("pc_104", out_pc, 32'h104);
      cyc(1, 32'h00800193, 32'h108, 0, 1, 0);
      check("ready_drop", in_ready, 1'b0);
      check("hold_104a",  out_pc,   32'h104);
      cyc(0, 32'h0, 32'h0, 0, 1, 0);
      check("hold_104b",  out_pc,   32'h104);
      cyc(0, 32'h0, 32'h0, 0, 1, 0);
      check("hold_104c",  out_pc,   32'h104);
      check("two_ready",  in_ready, 1'b0);
      cyc(0, 32'h0, 32'h0, 0, 0, 0);
      check("drain_108",  out_pc,   32'h108);
      check("drain_inst", out_inst, 32'h00800193);
      check("drain_rdy",  in_ready, 1'b1);
      cyc(0, 32'h0, 32'h0, 0, 0, 0);
      check("empty_valid", out_valid, 1'b0);
      check("empty_inst",  out_inst,  NOP);
      check("empty_pc",    out_pc,    32'h108);

      // Flush from TWO with a fetch presented
      cyc(1, 32'h00100213, 32'h110, 0, 0, 0);
      cyc(1, 32'h00200293, 32'h114, 0, 1, 0);
      check("two_again", in_ready, 1'b0);
      cyc(1, 32'h00300313, 32'h10C, 0, 0, 1);
      check("flush_valid", out_valid, 1'b0);
      check("flush_inst",  out_inst,  NOP);
      check("flush_take",  out_take,  1'b0);
      check("flush_ready", in_ready,  1'b1);

      // Flush from ONE while in_fire is true: 0x10C discarded
      cyc(1, 32'h00400393, 32'h118, 0, 0, 0);
      check("pc_118", out_pc, 32'h118);
      cyc(1, 32'h00300313, 32'h10C, 1, 0, 1);
      check("disc_valid", out_valid, 1'b0);
      cyc(0, 32'h0, 32'h0, 0, 0, 0);
      check("disc_still", out_valid, 1'b0);

      // Flush and stall together with take held
      cyc(1, 32'h00500413, 32'h120, 1, 0, 0);
      check("take_1", out_take, 1'b1);
      cyc(1, 32'h00600493, 32'h124, 1, 1, 1);
      check("fs_take",  out_take,  1'b0);
      check("fs_valid", out_valid, 1'b0);
      check("fs_ready", in_ready,  1'b1);

      // Stall while empty is ignored
      cyc(0, 32'h0, 32'h0, 0, 1, 0);
      check("es_valid", out_valid, 1'b0);
      cyc(1, 32'h00700513, 32'h128, 0, 1, 0);
      check("es_load", out_pc, 32'h128);

      // Reach TWO, then assert reset between edges
      cyc(1, 32'h00800593, 32'h12C, 0, 1, 0);
      check("pre_rst_two", in_ready, 1'b0);
      in_valid = 1'b0;
      stall    = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_inst",  out_inst,  NOP);
      check("mid_rst_pc",    out_pc,    32'h0);
      check("mid_rst_take",  out_take,  1'b0);
      check("mid_rst_ready", in_ready,  1'b1);
`ifdef IF_ID_STAGE_PERF_EN
      check("mid_rst_stc", stall_cycles, 32'h0);
      check("mid_rst_flc", flush_count,  32'h0);
`endif
      #3 reset = 1'b0;

      // Counter segment: five stalled valid cycles, two flushes
      cyc(1, 32'h00900613, 32'h200, 0, 0, 0);
      check("post_rst_pc", out_pc, 32'h200);
      for (int i = 0; i < 5; i++) cyc(0, 32'h0, 32'h0, 0, 1, 0);
      check("stall5_pc", out_pc, 32'h200);
      cyc(0, 32'h0, 32'h0, 0, 0, 0);
      cyc(0, 32'h0, 32'h0, 0, 0, 1);
      cyc(0, 32'h0, 32'h0, 0, 0, 1);
      cyc(0, 32'h0, 32'h0, 0, 0, 0);
`ifdef IF_ID_STAGE_PERF_EN
      check("perf_stall5", stall_cycles, 32'd5);
      check("perf_flush2", flush_count,  32'd2);
`endif
      check("end_valid", out_valid, 1'b0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
